// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: FSM states, opcode/funct
// encodings, aluOp codes and the ALU operation codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic opcode_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's aluOp (and funct for R-type) onto the datapath ALU code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unsupported funct falls back to ADD; DECODE flags it as illegal.
                case (funct)
                    F_ADD:   aluControl = ALU_ADD;
                    F_SUB:   aluControl = ALU_SUB;
                    F_AND:   aluControl = ALU_AND;
                    F_OR:    aluControl = ALU_OR;
                    F_SLT:   aluControl = ALU_SLT;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle MIPS datapath: drives enables, mux
// selects and the ALU code for each fetch/decode/execute/memory/writeback step.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcEn,
    output logic       iOrD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memtoReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic [2:0] aluControl,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic       pcWrite;
    logic       branch;
    logic [1:0] aluOp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_supported(funct) ? S_RTYPEEX : S_FETCH;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcWrite  = 1'b0;
        branch   = 1'b0;
        aluOp    = ALUOP_ADD;
        iOrD     = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        memtoReg = 1'b0;
        regDst   = 1'b0;
        regWrite = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        pcSrc    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irWrite = 1'b1;
                aluSrcB = 2'b01;
                pcWrite = 1'b1;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                illegal = !opcode_supported(opcode) ||
                          ((opcode == OP_RTYPE) && !funct_supported(funct));
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: iOrD = 1'b1;
            S_MEMWB: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEMWR: begin
                iOrD     = 1'b1;
                memWrite = 1'b1;
            end
            S_RTYPEEX: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_BEQEX: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_SUB;
                pcSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: regWrite = 1'b1;
            S_JEX: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
            end
            default: ;
        endcase

        pcEn = pcWrite | (branch & zero);

        // Reset overrides whatever state is held so no write can leak out mid-op.
        if (rst) begin
            pcEn     = 1'b0;
            iOrD     = 1'b0;
            memWrite = 1'b0;
            irWrite  = 1'b0;
            memtoReg = 1'b0;
            regDst   = 1'b0;
            regWrite = 1'b0;
            aluSrcA  = 1'b0;
            aluSrcB  = 2'b01;
            pcSrc    = 2'b00;
            aluOp    = ALUOP_ADD;
            illegal  = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .aluOp      (aluOp),
        .funct      (funct),
        .aluControl (aluControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle output vectors, compared every cycle.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcEn;
        logic       iOrD;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [2:0] aluControl;
        logic       illegal;
    } out_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] RTY  = 6'b000000;

    logic       clk = 1'b0;
    logic       rst, zero;
    logic [5:0] opcode, funct;
    logic       pcEn, iOrD, memWrite, irWrite, memtoReg, regDst, regWrite, aluSrcA, illegal;
    logic [1:0] aluSrcB, pcSrc;
    logic [2:0] aluControl;
    out_t       dut_v;

    out_t  exp_q[$];
    out_t  hist[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_fetch = 0;
    int    lat = 0;
    bit    rw_seen = 0;
    string cur = "";

    logic [5:0] r_fns[5]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] r_codes[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pcEn(pcEn), .iOrD(iOrD), .memWrite(memWrite), .irWrite(irWrite),
        .memtoReg(memtoReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
        .aluControl(aluControl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign dut_v = {pcEn, iOrD, memWrite, irWrite, memtoReg, regDst, regWrite, aluSrcA,
                    aluSrcB, pcSrc, aluControl, illegal};

    function automatic out_t base_v();
        out_t v = '0;
        v.aluControl = 3'b010;
        return v;
    endfunction

    function automatic out_t reset_v();
        out_t v = base_v();
        v.aluSrcB = 2'b01;
        return v;
    endfunction

    function automatic out_t fetch_v();
        out_t v = base_v();
        v.irWrite = 1'b1;
        v.aluSrcB = 2'b01;
        v.pcEn    = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] r_code(input logic [5:0] f);
        for (int i = 0; i < 5; i++) if (r_fns[i] == f) return r_codes[i];
        return 3'b010;
    endfunction

    function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
        bit fn_ok = 0;
        for (int i = 0; i < 5; i++) if (r_fns[i] == fn) fn_ok = 1;
        if (op == RTY) return fn_ok;
        return (op == LW) || (op == SW) || (op == BEQ) || (op == ADDI) || (op == JMP);
    endfunction

    // Expected cycles from DECODE through the following FETCH for one instruction.
    task automatic expand(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          output int n);
        out_t v;
        int   start = exp_q.size();
        v = base_v();
        v.aluSrcB = 2'b11;
        v.illegal = !legal(op, fn);
        exp_q.push_back(v);
        if (legal(op, fn)) begin
            if (op == LW || op == SW) begin
                v = base_v(); v.aluSrcA = 1'b1; v.aluSrcB = 2'b10; exp_q.push_back(v);
                if (op == LW) begin
                    v = base_v(); v.iOrD = 1'b1; exp_q.push_back(v);
                    v = base_v(); v.memtoReg = 1'b1; v.regWrite = 1'b1; exp_q.push_back(v);
                end else begin
                    v = base_v(); v.iOrD = 1'b1; v.memWrite = 1'b1; exp_q.push_back(v);
                end
            end else if (op == RTY) begin
                v = base_v(); v.aluSrcA = 1'b1; v.aluControl = r_code(fn); exp_q.push_back(v);
                v = base_v(); v.regDst = 1'b1; v.regWrite = 1'b1; exp_q.push_back(v);
            end else if (op == BEQ) begin
                v = base_v(); v.aluSrcA = 1'b1; v.aluControl = 3'b110; v.pcSrc = 2'b01;
                v.pcEn = z; exp_q.push_back(v);
            end else if (op == ADDI) begin
                v = base_v(); v.aluSrcA = 1'b1; v.aluSrcB = 2'b10; exp_q.push_back(v);
                v = base_v(); v.regWrite = 1'b1; exp_q.push_back(v);
            end else begin
                v = base_v(); v.pcSrc = 2'b10; v.pcEn = 1'b1; exp_q.push_back(v);
            end
        end
        exp_q.push_back(fetch_v());
        n = exp_q.size() - start;
    endtask

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // One cycle: sample on the falling edge, compare against the model, log history.
    task automatic tick();
        out_t e;
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_v !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", cur, cyc, dut_v, e);
            end
        end
        hist.push_back(dut_v);
        if (dut_v.regWrite) rw_seen = 1;
        if (dut_v.irWrite) begin
            lat = cyc - last_fetch;
            last_fetch = cyc;
        end
        #1;
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int exp_lat);
        int n;
        cur    = name;
        opcode = op;
        funct  = fn;
        zero   = z;
        hist.delete();
        expand(op, fn, z, n);
        repeat (n) tick();
        chk({name, " latency"}, lat, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst    = 1'b1;
        opcode = LW;
        funct  = 6'b0;
        zero   = 1'b0;
        cur    = "reset";
        repeat (3) exp_q.push_back(reset_v());
        repeat (3) tick();
        chk("reset enables", {hist[2].pcEn, hist[2].irWrite, hist[2].memWrite, hist[2].regWrite}, 0);

        @(posedge clk); #1;
        rst = 1'b0;
        cur = "release";
        hist.delete();
        exp_q.push_back(fetch_v());
        tick();
        chk("release irWrite", hist[0].irWrite, 1);
        chk("release pcEn", hist[0].pcEn, 1);
        chk("release aluControl", hist[0].aluControl, 3'b010);

        run("lw", LW, 6'b0, 1'b0, 5);
        chk("lw memrd iOrD", hist[2].iOrD, 1);
        chk("lw memwb memtoReg/regWrite/regDst", {hist[3].memtoReg, hist[3].regWrite, hist[3].regDst}, 3'b110);

        for (int i = 0; i < 5; i++) begin
            run("rtype", RTY, r_fns[i], 1'b0, 4);
            chk("rtype aluControl", hist[1].aluControl, r_codes[i]);
            chk("rtype wb regDst/regWrite", {hist[2].regDst, hist[2].regWrite}, 2'b11);
        end

        run("beq taken", BEQ, 6'b0, 1'b1, 3);
        chk("beq taken pcEn/pcSrc/aluControl", {hist[1].pcEn, hist[1].pcSrc, hist[1].aluControl}, 6'b101110);
        run("beq not taken", BEQ, 6'b0, 1'b0, 3);
        chk("beq not taken pcEn", hist[1].pcEn, 0);

        run("j", JMP, 6'b0, 1'b0, 3);
        chk("j pcSrc/pcEn", {hist[1].pcSrc, hist[1].pcEn}, 3'b101);
        run("sw", SW, 6'b0, 1'b0, 4);
        chk("sw memWrite/iOrD/regWrite", {hist[2].memWrite, hist[2].iOrD, hist[2].regWrite}, 3'b110);
        run("addi", ADDI, 6'b0, 1'b0, 4);
        chk("addi regWrite/regDst/memtoReg", {hist[2].regWrite, hist[2].regDst, hist[2].memtoReg}, 3'b100);

        run("illegal opcode", 6'b111111, 6'b0, 1'b0, 2);
        chk("illegal opcode pulse", {hist[0].illegal, hist[1].illegal}, 2'b10);
        run("illegal funct", RTY, 6'b000000, 1'b0, 2);
        chk("illegal funct pulse", {hist[0].illegal, hist[1].illegal}, 2'b10);

        // lw interrupted by reset while in MEMRD.
        cur    = "mid-op reset";
        opcode = LW;
        funct  = 6'b0;
        hist.delete();
        rw_seen = 0;
        expand(LW, 6'b0, 1'b0, n);
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        tick();
        tick();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.push_back(reset_v());
        tick();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(fetch_v());
        tick();
        chk("mid-op reset regWrite seen", rw_seen, 0);
        chk("mid-op reset then FETCH", hist[hist.size() - 1].irWrite, 1);

        run("j after reset", JMP, 6'b0, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
